// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NRD bypassed read ports, optional zero register,
// per-register busy scoreboard and a hardware clear sweep that runs after reset or on request.
module regfile_mp #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic                 clr,
    output logic                 ready,
    input  logic                 we0,
    input  logic [AW-1:0]        wa0,
    input  logic [WIDTH-1:0]     wd0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa1,
    input  logic [WIDTH-1:0]     wd1,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd,
    output logic [NRD-1:0]       busy,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_addr
);

    localparam logic          ZERO_EN = (ZERO_REG != 0);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     idx, idx_nxt;
    logic [DEPTH-1:0]  sb, sb_nxt;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic wr0, wr1, sb_set_eff, clr_go;

    assign ready      = (state == RUN);
    assign wr0        = we0 && clk_en && ready && !(ZERO_EN && wa0 == '0);
    assign wr1        = we1 && clk_en && ready && !(ZERO_EN && wa1 == '0);
    assign sb_set_eff = sb_set && clk_en && ready && !(ZERO_EN && sb_addr == '0);
    assign clr_go     = clr && clk_en && ready;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (clk_en) begin
            case (state)
                CLEAR: begin
                    idx_nxt = idx + 1'b1;
                    if (idx == LAST) begin
                        state_nxt = RUN;
                        idx_nxt   = '0;
                    end
                end
                RUN: begin
                    if (clr) begin
                        state_nxt = CLEAR;
                        idx_nxt   = '0;
                    end
                end
                default: state_nxt = CLEAR;
            endcase
        end
    end

    // A write retires the producer; a same-cycle set means a new producer is already in flight.
    always_comb begin
        sb_nxt = sb;
        if (clr_go) begin
            sb_nxt = '0;
        end else begin
            if (wr0)        sb_nxt[wa0]     = 1'b0;
            if (wr1)        sb_nxt[wa1]     = 1'b0;
            if (sb_set_eff) sb_nxt[sb_addr] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            idx   <= '0;
            sb    <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            sb    <= sb_nxt;
        end
    end

    // NOTE: the array has no reset; the sweep zeroes it, which keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (clk_en && !ready) begin
            mem[idx] <= '0;
        end else begin
            if (wr0) mem[wa0] <= wd0;
            if (wr1) mem[wa1] <= wd1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]    addr;
        logic             zero_hit, hit0, hit1;
        logic [WIDTH-1:0] data;

        assign addr     = ra[i*AW +: AW];
        assign zero_hit = ZERO_EN && (addr == '0);
        assign hit1     = wr1 && (wa1 == addr);
        assign hit0     = wr0 && (wa0 == addr);

        always_comb begin
            data = '0;
            if (ready && !zero_hit) begin
                if (hit1)      data = wd1;
                else if (hit0) data = wd0;
                else           data = mem[addr];
            end
        end

        assign rd[i*WIDTH +: WIDTH] = data;
        assign busy[i]              = ready && !zero_hit && sb[addr] && !(hit0 || hit1);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expectations are queued when stimulus is applied and
// compared against both a ZERO_REG=1 and a ZERO_REG=0 instance before the next edge.
module tb_regfile_mp;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int NRD   = 2;
    localparam int AW    = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clk_en = 1'b0;
    logic                 clr = 1'b0;
    logic                 we0 = 1'b0, we1 = 1'b0, sb_set = 1'b0;
    logic [AW-1:0]        wa0 = '0, wa1 = '0, sb_addr = '0;
    logic [WIDTH-1:0]     wd0 = '0, wd1 = '0;
    logic [NRD*AW-1:0]    ra = '0;
    logic [NRD*WIDTH-1:0] rd, rd_nz;
    logic [NRD-1:0]       busy, busy_nz;
    logic                 ready, ready_nz;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .clr(clr), .ready(ready),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd), .busy(busy), .sb_set(sb_set), .sb_addr(sb_addr)
    );

    regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .ZERO_REG(0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .clr(clr), .ready(ready_nz),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd_nz), .busy(busy_nz), .sb_set(sb_set), .sb_addr(sb_addr)
    );

    typedef enum int {K_RD, K_BUSY, K_READY, K_RD_NZ, K_BUSY_NZ} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_val(input string tag, input kind_t kind, input int port,
                              input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.port = port;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] observe(input kind_t kind, input int port);
        case (kind)
            K_RD:      return 32'(rd[port*WIDTH +: WIDTH]);
            K_BUSY:    return 32'(busy[port]);
            K_READY:   return 32'(ready);
            K_RD_NZ:   return 32'(rd_nz[port*WIDTH +: WIDTH]);
            K_BUSY_NZ: return 32'(busy_nz[port]);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, observe(e.kind, e.port), e.val);
        end
    endtask

    // Compare on the falling edge, then advance to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input int port, input logic [AW-1:0] addr);
        ra[port*AW +: AW] = addr;
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Reset held: not ready, reads and busy forced low.
        clk_en = 1'b1;
        expect_val("rst_ready", K_READY, 0, 0);
        expect_val("rst_rd0", K_RD, 0, 0);
        expect_val("rst_busy0", K_BUSY, 0, 0);
        step();
        step();

        // Release: exactly DEPTH sweep cycles; writes and sb_set during the sweep are ignored.
        rst_n = 1'b1;
        we0 = 1'b1; wa0 = 4'd4; wd0 = 8'h77;
        sb_set = 1'b1; sb_addr = 4'd4;
        set_ra(0, 4'd4);
        for (int c = 0; c < 17; c++) begin
            if (c == 15) begin
                we0 = 1'b0;
                sb_set = 1'b0;
            end
            expect_val($sformatf("sweep_ready c%0d", c), K_READY, 0, (c >= 16) ? 1 : 0);
            if (c < 16) expect_val($sformatf("sweep_rd0 c%0d", c), K_RD, 0, 0);
            step();
        end
        for (int r = 0; r < DEPTH; r++) begin
            set_ra(0, AW'(r));
            set_ra(1, AW'(DEPTH - 1 - r));
            expect_val($sformatf("clr_rd0 r%0d", r), K_RD, 0, 0);
            expect_val($sformatf("clr_rd1 r%0d", r), K_RD, 1, 0);
            expect_val($sformatf("clr_busy0 r%0d", r), K_BUSY, 0, 0);
            expect_val($sformatf("clr_rd_nz r%0d", r), K_RD_NZ, 0, 0);
            step();
        end

        // Same-cycle bypass and stored value.
        we0 = 1'b1; wa0 = 4'd3; wd0 = 8'hA5; set_ra(0, 4'd3);
        expect_val("byp_rd0", K_RD, 0, 8'hA5);
        step();
        we0 = 1'b0;
        expect_val("stored_rd0", K_RD, 0, 8'hA5);
        step();

        // Both ports to one register: port 1 wins.
        we0 = 1'b1; wa0 = 4'd5; wd0 = 8'h11;
        we1 = 1'b1; wa1 = 4'd5; wd1 = 8'h22;
        set_ra(0, 4'd5); set_ra(1, 4'd5);
        expect_val("dual_byp_rd0", K_RD, 0, 8'h22);
        expect_val("dual_byp_rd1", K_RD, 1, 8'h22);
        step();
        we0 = 1'b0; we1 = 1'b0;
        expect_val("dual_st_rd0", K_RD, 0, 8'h22);
        expect_val("dual_st_rd1", K_RD, 1, 8'h22);
        step();

        // Register 0: hardwired in dut, ordinary in dut_nz (set beats same-cycle write).
        we0 = 1'b1; wa0 = 4'd0; wd0 = 8'hFF;
        sb_set = 1'b1; sb_addr = 4'd0; set_ra(0, 4'd0);
        expect_val("z_byp_rd0", K_RD, 0, 0);
        expect_val("nz_byp_rd0", K_RD_NZ, 0, 8'hFF);
        step();
        we0 = 1'b0; sb_set = 1'b0;
        expect_val("z_rd0", K_RD, 0, 0);
        expect_val("z_busy0", K_BUSY, 0, 0);
        expect_val("nz_rd0", K_RD_NZ, 0, 8'hFF);
        expect_val("nz_busy0", K_BUSY_NZ, 0, 1);
        step();
        we1 = 1'b1; wa1 = 4'd0; wd1 = 8'hFF;
        expect_val("nz_busy0_byp", K_BUSY_NZ, 0, 0);
        expect_val("z_rd0_w1", K_RD, 0, 0);
        step();
        we1 = 1'b0;
        expect_val("nz_busy0_cleared", K_BUSY_NZ, 0, 0);
        step();

        // Scoreboard on register 7.
        sb_set = 1'b1; sb_addr = 4'd7; set_ra(1, 4'd7); set_ra(0, 4'd3);
        expect_val("sb_busy1_setcyc", K_BUSY, 1, 0);
        step();
        sb_set = 1'b0;
        expect_val("sb_busy1", K_BUSY, 1, 1);
        expect_val("sb_busy0_other", K_BUSY, 0, 0);
        expect_val("sb_rd1_old", K_RD, 1, 0);
        step();
        we1 = 1'b1; wa1 = 4'd7; wd1 = 8'h3C;
        expect_val("wb_busy1", K_BUSY, 1, 0);
        expect_val("wb_rd1", K_RD, 1, 8'h3C);
        step();
        we1 = 1'b0;
        expect_val("wb_busy1_after", K_BUSY, 1, 0);
        expect_val("wb_rd1_after", K_RD, 1, 8'h3C);
        step();
        sb_set = 1'b1; sb_addr = 4'd7;
        we0 = 1'b1; wa0 = 4'd7; wd0 = 8'h5A;
        expect_val("setwr_busy1", K_BUSY, 1, 0);
        expect_val("setwr_rd1", K_RD, 1, 8'h5A);
        step();
        sb_set = 1'b0; we0 = 1'b0;
        expect_val("setwr_busy1_next", K_BUSY, 1, 1);
        expect_val("setwr_rd1_next", K_RD, 1, 8'h5A);
        step();

        // clk_en low: write and sb_set on reg 2 have no effect.
        clk_en = 1'b0;
        we0 = 1'b1; wa0 = 4'd2; wd0 = 8'h99;
        sb_set = 1'b1; sb_addr = 4'd2; set_ra(0, 4'd2);
        expect_val("cen_rd0", K_RD, 0, 0);
        step();
        clk_en = 1'b1; we0 = 1'b0; sb_set = 1'b0;
        expect_val("cen_rd0_next", K_RD, 0, 0);
        expect_val("cen_busy0_next", K_BUSY, 0, 0);
        expect_val("cen_busy1_held", K_BUSY, 1, 1);
        step();

        // clr in RUN with a coincident write, then a sweep stretched by clk_en gaps.
        clr = 1'b1;
        we0 = 1'b1; wa0 = 4'd6; wd0 = 8'h42; set_ra(0, 4'd3);
        expect_val("clr_cyc_ready", K_READY, 0, 1);
        expect_val("clr_cyc_rd0", K_RD, 0, 8'hA5);
        step();
        clr = 1'b0; we0 = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40 && cnt <= 16; k++) begin
            expect_val($sformatf("csweep_ready k%0d", k), K_READY, 0, (cnt >= 16) ? 1 : 0);
            if (cnt < 16) expect_val($sformatf("csweep_busy1 k%0d", k), K_BUSY, 1, 0);
            clk_en = (k % 3 != 2);
            step();
            if (clk_en) cnt++;
        end
        check("csweep_done", 32'(cnt), 32'd17);
        clk_en = 1'b1;
        for (int r = 0; r < DEPTH; r++) begin
            set_ra(0, AW'(r));
            set_ra(1, AW'(r));
            expect_val($sformatf("c2_rd0 r%0d", r), K_RD, 0, 0);
            expect_val($sformatf("c2_busy1 r%0d", r), K_BUSY, 1, 0);
            expect_val($sformatf("c2_busy_nz r%0d", r), K_BUSY_NZ, 0, 0);
            step();
        end

        // Async reset after 5 sweep cycles: sweep restarts and takes a full DEPTH cycles.
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        expect_val("midsweep_ready", K_READY, 0, 0);
        drain();
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 17; c++) begin
            expect_val($sformatf("resweep_ready c%0d", c), K_READY, 0, (c >= 16) ? 1 : 0);
            step();
        end

        // Async reset mid-RUN drops ready and reads without waiting for an edge.
        we0 = 1'b1; wa0 = 4'd8; wd0 = 8'h33; set_ra(0, 4'd8);
        step();
        we0 = 1'b0;
        expect_val("run_rd0", K_RD, 0, 8'h33);
        step();
        rst_n = 1'b0;
        #1;
        expect_val("runrst_ready", K_READY, 0, 0);
        expect_val("runrst_rd0", K_RD, 0, 0);
        drain();
        step();
        rst_n = 1'b1;
        repeat (16) step();
        expect_val("final_ready", K_READY, 0, 1);
        expect_val("final_rd0", K_RD, 0, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the BatPU2 core and its wider derivatives. It provides two write ports, NRD combinational read ports with same-cycle write bypass, and an optional hardwired zero register. A per-register busy scoreboard supports multi-cycle producers. A hardware clear sequencer zeroes the whole array after reset or on request. It sits between decode (read addresses, scoreboard set) and writeback (write ports).

## Interface
Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 16, number of registers; must be a power of two ≥ 2; AW = log2(DEPTH).
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/scoreboard set; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clk_en  in  1  global clock enable; when 0, no state changes (FSM, storage, scoreboard hold).
- clr  in  1  request full clear (sampled in RUN with clk_en).
- ready  out  1  1 in RUN; 0 while clearing.
- we0 / wa0 / wd0  in  1 / AW / WIDTH  write port 0.
- we1 / wa1 / wd1  in  1 / AW / WIDTH  write port 1 (higher priority).
- ra  in  NRD*AW  read addresses, port i at bits [i*AW +: AW].
- rd  out  NRD*WIDTH  read data, port i at [i*WIDTH +: WIDTH].
- busy  out  NRD  scoreboard status of each read port's register.
- sb_set  in  1  mark register sb_addr busy.
- sb_addr  in  AW  scoreboard set address.

## Operation
- Effective write: wrN = weN & clk_en & ready & ~(ZERO_REG & waN==0).
- Storage: on posedge, if wr0 then mem[wa0]<=wd0; if wr1 then mem[wa1]<=wd1. wa0==wa1 with both writing: port 1 value stored.
- Read port i (combinational): not ready → 0. ZERO_REG & ra_i==0 → 0. Otherwise wr1 & wa1==ra_i → wd1; else wr0 & wa0==ra_i → wd0; else mem[ra_i].
- Scoreboard sb[DEPTH]: set when sb_set & clk_en & ready (ignored for reg 0 when ZERO_REG). Cleared by any effective write to that address. Same-cycle set and write-clear of the same address: set wins (new producer in flight).
- busy_i = ready & sb[ra_i] & ~(bypass hit on port i this cycle). busy is 0 for reg 0 when ZERO_REG.
- FSM states: CLEAR, RUN.
  - CLEAR: each clk_en cycle writes 0 to mem[idx], idx++. On idx==DEPTH-1, go to RUN next edge. Writes, sb_set and clr are ignored.
  - RUN: clr & clk_en → CLEAR with idx=0 and all sb=0 at that edge. Writes presented in that same cycle still commit, but are then overwritten by the sweep.
- Reset (rst_n=0, asynchronous): state=CLEAR, idx=0, sb all 0. Outputs during and after reset until RUN: ready=0, rd all 0, busy all 0. Storage itself is not reset directly; the sweep zeroes it.
- Reset asserted mid-sweep or mid-RUN: immediate return to CLEAR, idx=0, and the sweep restarts from register 0.

## Timing
- Read latency 0 cycles, combinational from ra/we/wa/wd.
- Write visible on the same cycle via bypass, and from storage on the following cycle.
- Clear duration: exactly DEPTH clk_en-qualified cycles after rst_n release, or after the clr edge. ready rises on the edge that ends the DEPTH-th sweep cycle.
- clk_en=0 cycles stretch the sweep and do not advance idx.
- Scoreboard changes are visible on busy the cycle after the sb_set edge.

## Test plan
- Reset/clear: hold rst_n=0, release, keep clk_en=1 (DEPTH=16). Expect ready=0 for 16 cycles, then ready=1, and every register reads 0x00. we0 during the sweep has no effect.
- Write/bypass: we0=1, wa0=3, wd0=0xA5, ra[0]=3 in the same cycle. Expect rd[0]=0xA5 that cycle and from storage the next cycle. With we0 and we1 both to reg 5 (0x11/0x22), expect rd=0x22 both same-cycle and stored.
- Zero register: write 0xFF to reg 0 with ZERO_REG=1. Expect rd=0x00 and busy=0 after sb_set on reg 0. With ZERO_REG=0, expect rd=0xFF next cycle.
- Scoreboard: sb_set reg 7, then ra[1]=7. Expect busy[1]=1. In the writeback cycle for reg 7 (0x3C), expect busy[1]=0 and rd[1]=0x3C. Simultaneous sb_set and write on reg 7 leaves busy[1]=1 next cycle.
- clk_en gating: clk_en=0 with we0=1 writing reg 2 → no change, and the sweep pauses. Assert clr in RUN → ready=0 next cycle, the sweep runs 16 enabled cycles, and all registers read 0 with no busy bits set.
- Async reset mid-sweep: pull rst_n low after 5 sweep cycles. Expect ready=0 immediately and the sweep to restart, taking a full 16 cycles after release.
